// File: rtl/rssb_pkg.sv
// Shared types for the rssb trace capture path: field order of a trace record
// and the output beat FSM states.
package rssb_pkg;

    localparam int unsigned NUM_FIELDS = 5;
    localparam int unsigned TRACE_W    = 8;

    typedef enum logic [2:0] {
        TF_PC,
        TF_MEM,
        TF_OP1,
        TF_SUB,
        TF_ACC
    } trace_field_e;

    typedef enum logic {
        StEmpty,
        StSend
    } out_state_e;

    typedef struct packed {
        logic [TRACE_W-1:0] pc;
        logic [TRACE_W-1:0] mem;
        logic [TRACE_W-1:0] op1;
        logic [TRACE_W-1:0] sub;
        logic [TRACE_W-1:0] acc;
    } trace_rec_t;

endpackage

// File: rtl/rssb_sync_fifo.sv
// Single-clock FIFO of records; the head entry is read combinationally.
// Push and pop in the same cycle are both honoured, including when full.
module rssb_sync_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    output T                       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [LVL_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PTR_W'(1);
            if (i_pop)  r_rd <= r_rd + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + LVL_W'(1);
                2'b01:   r_cnt <= r_cnt - LVL_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_full  = (r_cnt == LVL_W'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_level = r_cnt;

endmodule

// File: rtl/rssb_trace_capture.sv
// Captures one rssb trace record per pc change into a FIFO and streams each
// record out as five word beats (PC, MEM, OP1, SUB, ACC) over valid/ready.
module rssb_trace_capture
    import rssb_pkg::*;
#(
    parameter int unsigned WIDTH = TRACE_W,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic [WIDTH-1:0]         i_ipc,
    input  logic [WIDTH-1:0]         i_imem,
    input  logic [WIDTH-1:0]         i_iop1,
    input  logic [WIDTH-1:0]         i_isub,
    input  logic [WIDTH-1:0]         i_iacc,
    output logic [WIDTH-1:0]         o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic                     o_out_last,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic [CNT_W-1:0]         o_drop_cnt,
    input  logic                     i_clr_ovf
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] mem;
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] sub;
        logic [WIDTH-1:0] acc;
    } rec_t;

    rec_t             w_rec;
    rec_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;
    logic             w_trig;
    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    out_state_e       r_state;
    trace_field_e     r_beat;
    logic [WIDTH-1:0] r_last_pc;
    logic             r_primed;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    assign w_rec    = {i_ipc, i_imem, i_iop1, i_isub, i_iacc};
    assign w_trig   = i_en && (!r_primed || (i_ipc != r_last_pc));
    assign w_accept = (r_state == StSend) && !w_empty && i_out_ready;
    assign w_pop    = w_accept && (r_beat == TF_ACC);
    // A full FIFO still takes a record when the head retires on this edge.
    assign w_push   = w_trig && (!w_full || w_pop);
    assign w_drop   = w_trig && !w_push;

    rssb_sync_fifo #(
        .T     (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= StEmpty;
            r_beat     <= TF_PC;
            r_last_pc  <= '0;
            r_primed   <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (i_en) begin
                r_last_pc <= i_ipc;
                r_primed  <= 1'b1;
            end else begin
                r_primed  <= 1'b0;
            end

            // Clear takes effect first, so a same-cycle drop is still counted.
            if (i_clr_ovf) begin
                r_overflow <= w_drop;
                r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end

            case (r_state)
                StEmpty: begin
                    if (w_push) r_state <= StSend;
                end
                StSend: begin
                    if (w_accept) begin
                        if (r_beat == TF_ACC) begin
                            r_beat <= TF_PC;
                            if ((w_level == LVL_W'(1)) && !w_push) r_state <= StEmpty;
                        end else begin
                            r_beat <= trace_field_e'(r_beat + 3'd1);
                        end
                    end
                end
                default: r_state <= StEmpty;
            endcase
        end
    end

    always_comb begin
        o_out_data = '0;
        if (r_state == StSend) begin
            case (r_beat)
                TF_PC:   o_out_data = w_head.pc;
                TF_MEM:  o_out_data = w_head.mem;
                TF_OP1:  o_out_data = w_head.op1;
                TF_SUB:  o_out_data = w_head.sub;
                TF_ACC:  o_out_data = w_head.acc;
                default: o_out_data = '0;
            endcase
        end
    end

    assign o_out_valid = (r_state == StSend);
    assign o_out_last  = (r_state == StSend) && (r_beat == TF_ACC);
    assign o_level     = w_level;
    assign o_overflow  = r_overflow;
    assign o_drop_cnt  = r_drop_cnt;

endmodule
